mezz_pwm_ctrl: RTL and testbench



---
 rtl/mezz_pwm_pkg.sv | 46 ++++
 rtl/mezz_pwm_channel.sv | 80 ++++++++
 rtl/mezz_pwm_ctrl.sv | 119 +++++++++++
 tb/tb_mezz_pwm_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mezz_pwm_pkg.sv
// Shared register map, CTRL field layout and helpers for the mezzanine PWM controller.
package mezz_pwm_pkg;

   localparam int unsigned CFG_AW = 4;
   localparam int unsigned CFG_DW = 16;
   localparam int unsigned STEP_W = 8;

   localparam logic [CFG_AW-1:0] ADDR_PRESCALE = 4'h0;
   localparam logic [CFG_AW-1:0] ADDR_STATUS   = 4'h1;
   localparam int unsigned       CH_BASE       = 4;
   localparam logic [CFG_AW-1:0] OFS_PERIOD    = 4'h0;
   localparam logic [CFG_AW-1:0] OFS_DUTY      = 4'h1;
   localparam logic [CFG_AW-1:0] OFS_CTRL      = 4'h2;

   localparam int unsigned CTRL_EN_BIT      = 0;
   localparam int unsigned CTRL_INV_BIT     = 1;
   localparam int unsigned CTRL_RAMP_EN_BIT = 2;
   localparam int unsigned CTRL_STEP_LSB    = 8;

   typedef struct packed {
      logic [STEP_W-1:0] ramp_step;
      logic              ramp_en;
      logic              inv;
      logic              en;
   } ctrl_t;

   function automatic ctrl_t word_to_ctrl(input logic [CFG_DW-1:0] w);
      ctrl_t c;
      c.en        = w[CTRL_EN_BIT];
      c.inv       = w[CTRL_INV_BIT];
      c.ramp_en   = w[CTRL_RAMP_EN_BIT];
      c.ramp_step = w[CTRL_STEP_LSB +: STEP_W];
      return c;
   endfunction

   function automatic logic [CFG_DW-1:0] ctrl_to_word(input ctrl_t c);
      logic [CFG_DW-1:0] w;
      w                           = '0;
      w[CTRL_EN_BIT]              = c.en;
      w[CTRL_INV_BIT]             = c.inv;
      w[CTRL_RAMP_EN_BIT]         = c.ramp_en;
      w[CTRL_STEP_LSB +: STEP_W]  = c.ramp_step;
      return w;
   endfunction

endpackage

// File: rtl/mezz_pwm_channel.sv
// One PWM channel: period counter, shadowed period/duty with soft-start ramp, registered outputs.
module mezz_pwm_channel
   import mezz_pwm_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] duty,
   input  ctrl_t            ctrl,
   output logic             pwm,
   output logic             wrap,
   output logic             ramp_busy
);

   localparam int unsigned W1 = CNT_W + 1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period_act;
   logic [CNT_W-1:0] duty_act;
   logic             en_q;
   logic [W1-1:0]    step_c;
   logic [W1-1:0]    diff_c;
   logic [CNT_W-1:0] duty_next_c;

   // Next duty at a wrap: direct load, or a saturating step toward the target.
   always_comb begin
      step_c      = W1'(ctrl.ramp_step);
      diff_c      = '0;
      duty_next_c = duty_act;
      if (!ctrl.ramp_en) begin
         duty_next_c = duty;
      end else if (duty_act < duty) begin
         diff_c      = {1'b0, duty} - {1'b0, duty_act};
         duty_next_c = (diff_c <= step_c) ? duty : duty_act + CNT_W'(ctrl.ramp_step);
      end else if (duty_act > duty) begin
         diff_c      = {1'b0, duty_act} - {1'b0, duty};
         duty_next_c = (diff_c <= step_c) ? duty : duty_act - CNT_W'(ctrl.ramp_step);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         period_act <= '0;
         duty_act   <= '0;
         en_q       <= 1'b0;
         pwm        <= 1'b0;
         wrap       <= 1'b0;
         ramp_busy  <= 1'b0;
      end else begin
         en_q      <= ctrl.en;
         wrap      <= 1'b0;
         ramp_busy <= ctrl.en && (duty_act != duty);
         pwm       <= ctrl.en ? ((cnt < duty_act) ^ ctrl.inv) : ctrl.inv;
         if (!ctrl.en) begin
            cnt <= '0;
         end else if (!en_q) begin
            // Enable edge: restart cleanly; with ramp on, duty_act is kept for soft-start.
            cnt        <= '0;
            period_act <= period;
            if (!ctrl.ramp_en) begin
               duty_act <= duty;
            end
         end else if (tick) begin
            if (cnt == period_act) begin
               cnt        <= '0;
               wrap       <= 1'b1;
               period_act <= period;
               duty_act   <= duty_next_c;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/mezz_pwm_ctrl.sv
// PWM controller top: PS register file, shared prescaler, read mux and N_CH channels.
module mezz_pwm_ctrl
   import mezz_pwm_pkg::*;
#(
   parameter int unsigned N_CH  = 3,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned PRE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_wr,
   input  logic              cfg_rd,
   input  logic [CFG_AW-1:0] cfg_addr,
   input  logic [CFG_DW-1:0] cfg_wdata,
   output logic [CFG_DW-1:0] cfg_rdata,
   output logic              cfg_rvalid,
   output logic [N_CH-1:0]   pwm_o,
   output logic [N_CH-1:0]   wrap_o,
   output logic [N_CH-1:0]   ramp_busy_o
);

   logic [PRE_W-1:0] prescale;
   logic [PRE_W-1:0] pre_cnt;
   logic [CNT_W-1:0] period_q [N_CH];
   logic [CNT_W-1:0] duty_q   [N_CH];
   ctrl_t            ctrl_q   [N_CH];

   logic              tick_c;
   logic              pre_we_c;
   logic [N_CH-1:0]   per_we_c;
   logic [N_CH-1:0]   duty_we_c;
   logic [N_CH-1:0]   ctrl_we_c;
   logic [CFG_DW-1:0] rd_mux_c;

   assign tick_c = (pre_cnt == prescale);

   // Address decode: write enables and read data for the current address.
   always_comb begin
      pre_we_c  = cfg_wr && (cfg_addr == ADDR_PRESCALE);
      per_we_c  = '0;
      duty_we_c = '0;
      ctrl_we_c = '0;
      rd_mux_c  = '0;
      case (cfg_addr)
         ADDR_PRESCALE: rd_mux_c = CFG_DW'(prescale);
         ADDR_STATUS:   rd_mux_c = CFG_DW'(ramp_busy_o);
         default:       rd_mux_c = '0;
      endcase
      for (int n = 0; n < N_CH; n++) begin
         if (cfg_addr == CFG_AW'(CH_BASE * (n + 1)) + OFS_PERIOD) begin
            per_we_c[n] = cfg_wr;
            rd_mux_c    = CFG_DW'(period_q[n]);
         end
         if (cfg_addr == CFG_AW'(CH_BASE * (n + 1)) + OFS_DUTY) begin
            duty_we_c[n] = cfg_wr;
            rd_mux_c     = CFG_DW'(duty_q[n]);
         end
         if (cfg_addr == CFG_AW'(CH_BASE * (n + 1)) + OFS_CTRL) begin
            ctrl_we_c[n] = cfg_wr;
            rd_mux_c     = ctrl_to_word(ctrl_q[n]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale   <= '0;
         pre_cnt    <= '0;
         cfg_rdata  <= '0;
         cfg_rvalid <= 1'b0;
         for (int n = 0; n < N_CH; n++) begin
            period_q[n] <= '0;
            duty_q[n]   <= '0;
            ctrl_q[n]   <= '0;
         end
      end else begin
         if (pre_we_c) begin
            prescale <= PRE_W'(cfg_wdata);
         end
         // A PRESCALE write restarts the divider so the new rate starts from a clean phase.
         if (pre_we_c || tick_c) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
         end
         for (int n = 0; n < N_CH; n++) begin
            if (per_we_c[n]) begin
               period_q[n] <= CNT_W'(cfg_wdata);
            end
            if (duty_we_c[n]) begin
               duty_q[n] <= CNT_W'(cfg_wdata);
            end
            if (ctrl_we_c[n]) begin
               ctrl_q[n] <= word_to_ctrl(cfg_wdata);
            end
         end
         // Read data is sampled from pre-write register state.
         cfg_rvalid <= cfg_rd;
         cfg_rdata  <= cfg_rd ? rd_mux_c : '0;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      mezz_pwm_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .tick      (tick_c),
         .period    (period_q[g]),
         .duty      (duty_q[g]),
         .ctrl      (ctrl_q[g]),
         .pwm       (pwm_o[g]),
         .wrap      (wrap_o[g]),
         .ramp_busy (ramp_busy_o[g])
      );
   end

endmodule

// File: tb/tb_mezz_pwm_ctrl.sv
// Directed self-checking bench for mezz_pwm_ctrl with hand-computed expectations.
module tb_mezz_pwm_ctrl;

   localparam int unsigned N_CH = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_wr;
   logic              cfg_rd;
   logic [3:0]        cfg_addr;
   logic [15:0]       cfg_wdata;
   logic [15:0]       cfg_rdata;
   logic              cfg_rvalid;
   logic [N_CH-1:0]   pwm_o;
   logic [N_CH-1:0]   wrap_o;
   logic [N_CH-1:0]   ramp_busy_o;

   int n_checks = 0;
   int n_errors = 0;
   int hi;
   int wr;

   always #5 clk = ~clk;

   mezz_pwm_ctrl #(
      .N_CH  (N_CH),
      .CNT_W (16),
      .PRE_W (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_wr      (cfg_wr),
      .cfg_rd      (cfg_rd),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .cfg_rdata   (cfg_rdata),
      .cfg_rvalid  (cfg_rvalid),
      .pwm_o       (pwm_o),
      .wrap_o      (wrap_o),
      .ramp_busy_o (ramp_busy_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      cfg_wr    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(negedge clk);
      cfg_wr    = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
      @(negedge clk);
      cfg_rd   = 1'b1;
      cfg_addr = a;
      @(negedge clk);
      cfg_rd   = 1'b0;
      check({tag, "_rvalid"}, 32'(cfg_rvalid), 32'd1);
      check(tag, 32'(cfg_rdata), 32'(exp));
   endtask

   task automatic wait_wrap(input int ch);
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = wrap_o[ch];
      end
      check("wrap_seen", 32'(seen), 32'd1);
   endtask

   // Counts high cycles and wrap pulses over len clocks; optionally issues one write at cycle wr_at.
   task automatic measure(input int ch, input int len, input int wr_at,
                          input logic [3:0] wa, input logic [15:0] wd,
                          output int h, output int w);
      h = 0;
      w = 0;
      for (int i = 1; i <= len; i++) begin
         @(negedge clk);
         if (pwm_o[ch])  h++;
         if (wrap_o[ch]) w++;
         cfg_wr    = (i == wr_at);
         cfg_addr  = wa;
         cfg_wdata = wd;
      end
      cfg_wr = 1'b0;
   endtask

   task automatic check_period(input string tag, input int ch, input int len,
                               input int exp_hi, input int exp_wr);
      int h;
      int w;
      measure(ch, len, 0, 4'h0, 16'h0, h, w);
      check({tag, "_hi"}, 32'(h), 32'(exp_hi));
      check({tag, "_wrap"}, 32'(w), 32'(exp_wr));
   endtask

   initial begin
      rst       = 1'b1;
      cfg_wr    = 1'b0;
      cfg_rd    = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_pwm", 32'(pwm_o), 32'd0);
      check("rst_wrap", 32'(wrap_o), 32'd0);
      check("rst_busy", 32'(ramp_busy_o), 32'd0);
      check("rst_rvalid", 32'(cfg_rvalid), 32'd0);
      check("rst_rdata", 32'(cfg_rdata), 32'd0);
      rst = 1'b0;
      read_check("rst_prescale", 4'h0, 16'h0000);

      // Basic PWM, then a mid-period duty change on ch0.
      cfg_write(4'h0, 16'd0);
      cfg_write(4'h4, 16'd9);
      cfg_write(4'h5, 16'd3);
      cfg_write(4'h6, 16'h0001);
      wait_wrap(0);
      check_period("p1a", 0, 10, 3, 1);
      check_period("p1b", 0, 10, 3, 1);
      measure(0, 10, 2, 4'h5, 16'd7, hi, wr);
      check("p2_old_hi", 32'(hi), 32'd3);
      check("p2_old_wrap", 32'(wr), 32'd1);
      check_period("p2_new", 0, 10, 7, 1);

      // Soft-start ramp on ch1 from duty_act=0 toward 5 in steps of 2.
      cfg_write(4'h8, 16'd9);
      cfg_write(4'h9, 16'd5);
      cfg_write(4'hA, 16'h0205);
      wait_wrap(1);
      check("ramp_busy_early", 32'(ramp_busy_o[1]), 32'd1);
      check_period("ramp_2", 1, 10, 2, 1);
      check_period("ramp_4", 1, 10, 4, 1);
      check("ramp_busy_mid", 32'(ramp_busy_o[1]), 32'd1);
      check_period("ramp_5a", 1, 10, 5, 1);
      check("ramp_busy_done", 32'(ramp_busy_o[1]), 32'd0);
      check_period("ramp_5b", 1, 10, 5, 1);
      cfg_write(4'hA, 16'h0000);

      // Boundaries on ch0.
      cfg_write(4'h5, 16'd12);
      wait_wrap(0);
      check_period("duty_gt_per", 0, 10, 10, 1);
      cfg_write(4'h5, 16'd0);
      wait_wrap(0);
      check_period("duty_zero", 0, 10, 0, 1);
      cfg_write(4'h6, 16'h0002);
      repeat (2) @(negedge clk);
      check("idle_inv", 32'(pwm_o[0]), 32'd1);
      check_period("idle_inv_run", 0, 20, 20, 0);
      cfg_write(4'h4, 16'd0);
      cfg_write(4'h5, 16'd1);
      cfg_write(4'h6, 16'h0001);
      repeat (3) @(negedge clk);
      check_period("per_zero", 0, 10, 10, 10);

      // Prescaled operation: one counter step per 4 clocks.
      cfg_write(4'h0, 16'd3);
      cfg_write(4'h4, 16'd1);
      cfg_write(4'h5, 16'd1);
      wait_wrap(0);
      wait_wrap(0);
      check_period("pre3a", 0, 8, 4, 1);
      check_period("pre3b", 0, 8, 4, 1);

      // Register access.
      cfg_write(4'h8, 16'h1234);
      read_check("rd_ch1_period", 4'h8, 16'h1234);
      cfg_write(4'h9, 16'h0055);
      read_check("rd_ch1_duty", 4'h9, 16'h0055);
      @(negedge clk);
      cfg_wr    = 1'b1;
      cfg_rd    = 1'b1;
      cfg_addr  = 4'h8;
      cfg_wdata = 16'hBEEF;
      @(negedge clk);
      cfg_wr = 1'b0;
      cfg_rd = 1'b0;
      check("rw_same_rvalid", 32'(cfg_rvalid), 32'd1);
      check("rw_same_old", 32'(cfg_rdata), 32'h1234);
      read_check("rw_same_new", 4'h8, 16'hBEEF);
      read_check("rd_unmapped_f", 4'hF, 16'h0000);
      read_check("rd_unmapped_3", 4'h3, 16'h0000);
      read_check("rd_ch0_ctrl", 4'h6, 16'h0001);
      read_check("rd_prescale", 4'h0, 16'h0003);
      cfg_write(4'hD, 16'd100);
      cfg_write(4'hE, 16'h0105);
      read_check("rd_ch2_ctrl", 4'hE, 16'h0105);
      read_check("rd_status", 4'h1, 16'h0004);
      cfg_write(4'h1, 16'hFFFF);
      read_check("rd_status_ro", 4'h1, 16'h0004);

      // Mid-run reset with ch0 inverted and running.
      cfg_write(4'h6, 16'h0003);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_pwm", 32'(pwm_o), 32'd0);
      check("mrst_wrap", 32'(wrap_o), 32'd0);
      check("mrst_busy", 32'(ramp_busy_o), 32'd0);
      check("mrst_rvalid", 32'(cfg_rvalid), 32'd0);
      rst = 1'b0;
      read_check("mrst_prescale", 4'h0, 16'h0000);
      read_check("mrst_ch0_ctrl", 4'h6, 16'h0000);
      read_check("mrst_ch2_duty", 4'hD, 16'h0000);
      repeat (5) @(negedge clk);
      check("mrst_pwm_after", 32'(pwm_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
